// File: rtl/pio_pkg.sv
// Shared definitions for the PIO pin bank: pad count default, window and
// rotate helpers over an n-pin ring (n a power of two, at most 32).
package pio_pkg;

  localparam int NUM_PINS = 32;
  localparam int SS_MAX   = 5;
  localparam int SET_MAX  = 5;

  // Rotate left by base over the low n bits; bits at or above n read as zero.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned base,
                                       input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++)
      if (i < n) r[5'((i + base) & (n - 1))] = v[i];
    return r;
  endfunction

  // Rotate right by base over the low n bits; bits at or above n read as zero.
  function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned base,
                                       input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++)
      if (i < n) r[i] = v[5'((i + base) & (n - 1))];
    return r;
  endfunction

  // cnt contiguous ones starting at pad base, wrapping; cnt >= n saturates to
  // all n pads. Built bit by bit so a full-width count never shifts past 32.
  function automatic logic [31:0] window_mask(input int unsigned cnt, input int unsigned base,
                                              input int unsigned n);
    logic [31:0] raw;
    raw = '0;
    for (int unsigned i = 0; i < 32; i++)
      raw[i] = (i < n) && (i < cnt);
    return rotl(raw, base, n);
  endfunction

endpackage

// File: rtl/pio_pin_sync.sv
// Per-bit two-flop synchronizer for asynchronous pad inputs, reset to 0.
module pio_pin_sync #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1;

  // Two back-to-back capture stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/pio_pin_bank.sv
// GPIO bank for one PIO state machine: OUT/SET/SIDESET writes into wrapping
// pad windows, IN window readback and a registered WAIT-pin condition.
// Build option PIO_PIN_SYNC_EN: sample pads through a 2-flop synchronizer.
module pio_pin_bank
  import pio_pkg::*;
#(
  parameter  int NUM_PINS = pio_pkg::NUM_PINS,
  localparam int BASE_W   = $clog2(NUM_PINS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BASE_W-1:0]   cfg_in_base,
  input  logic [BASE_W-1:0]   cfg_out_base,
  input  logic [5:0]          cfg_out_count,
  input  logic [BASE_W-1:0]   cfg_set_base,
  input  logic [2:0]          cfg_set_count,
  input  logic [BASE_W-1:0]   cfg_ss_base,
  input  logic [2:0]          cfg_ss_count,
  input  logic [31:0]         out_data,
  input  logic                out_we,
  input  logic [4:0]          set_data,
  input  logic                set_we,
  input  logic [4:0]          ss_data,
  input  logic                ss_we,
  input  logic                dir_sel,
  input  logic [BASE_W-1:0]   wait_idx,
  input  logic                wait_pol,
  output logic [31:0]         in_data,
  output logic                wait_met,
  input  logic [NUM_PINS-1:0] pads_in,
  output logic [NUM_PINS-1:0] pads_out,
  output logic [NUM_PINS-1:0] pads_oe
);

  logic [NUM_PINS-1:0] pinSample;
  logic [NUM_PINS-1:0] outMask, setMask, ssMask;
  logic [NUM_PINS-1:0] outVal, setVal, ssVal;
  logic [NUM_PINS-1:0] nextOut, nextOe;
  logic [BASE_W-1:0]   waitPad;

`ifdef PIO_PIN_SYNC_EN
  pio_pin_sync #(.W(NUM_PINS)) uSync (
    .clock (clock),
    .reset (reset),
    .d     (pads_in),
    .q     (pinSample)
  );
`else
  assign pinSample = pads_in;
`endif

  assign outMask = NUM_PINS'(window_mask(32'(cfg_out_count), 32'(cfg_out_base), NUM_PINS));
  assign setMask = NUM_PINS'(window_mask((cfg_set_count > 3'(SET_MAX)) ? 32'(SET_MAX) : 32'(cfg_set_count),
                                         32'(cfg_set_base), NUM_PINS));
  assign ssMask  = NUM_PINS'(window_mask((cfg_ss_count > 3'(SS_MAX)) ? 32'(SS_MAX) : 32'(cfg_ss_count),
                                         32'(cfg_ss_base), NUM_PINS));
  assign outVal  = NUM_PINS'(rotl(out_data, 32'(cfg_out_base), NUM_PINS));
  assign setVal  = NUM_PINS'(rotl(32'(set_data), 32'(cfg_set_base), NUM_PINS));
  assign ssVal   = NUM_PINS'(rotl(32'(ss_data), 32'(cfg_ss_base), NUM_PINS));

  // Base-field width equals log2(NUM_PINS), so the add wraps modulo the pad count.
  assign waitPad = cfg_in_base + wait_idx;
  assign in_data = rotr(32'(pinSample), 32'(cfg_in_base), NUM_PINS);

  // Merge strobes in ascending priority so later writes win on overlapping pads.
  always_comb begin
    nextOut = pads_out;
    nextOe  = pads_oe;
    if (out_we) begin
      if (dir_sel) nextOe  = (nextOe  & ~outMask) | (outVal & outMask);
      else         nextOut = (nextOut & ~outMask) | (outVal & outMask);
    end
    if (set_we) begin
      if (dir_sel) nextOe  = (nextOe  & ~setMask) | (setVal & setMask);
      else         nextOut = (nextOut & ~setMask) | (setVal & setMask);
    end
    if (ss_we)
      nextOut = (nextOut & ~ssMask) | (ssVal & ssMask);
  end

  // Commit pad state and the WAIT condition; reset overrides any strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      pads_out <= '0;
      pads_oe  <= '0;
      wait_met <= 1'b0;
    end else begin
      pads_out <= nextOut;
      pads_oe  <= nextOe;
      wait_met <= (pinSample[waitPad] == wait_pol);
    end
  end

endmodule

// File: tb/tb_pio_pin_bank.sv
module tb_pio_pin_bank;

  localparam int N = 32;
`ifdef PIO_PIN_SYNC_EN
  localparam int LAT_IN = 2;
  localparam int LAT_W  = 3;
`else
  localparam int LAT_IN = 0;
  localparam int LAT_W  = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  cfg_in_base, cfg_out_base, cfg_set_base, cfg_ss_base, wait_idx;
  logic [5:0]  cfg_out_count;
  logic [2:0]  cfg_set_count, cfg_ss_count;
  logic [31:0] out_data;
  logic [4:0]  set_data, ss_data;
  logic        out_we, set_we, ss_we, dir_sel, wait_pol;
  logic [31:0] in_data;
  logic        wait_met;
  logic [N-1:0] pads_in, pads_out, pads_oe;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pio_pin_bank #(.NUM_PINS(N)) dut (
    .clock(clock), .reset(reset),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base), .cfg_out_count(cfg_out_count),
    .cfg_set_base(cfg_set_base), .cfg_set_count(cfg_set_count),
    .cfg_ss_base(cfg_ss_base), .cfg_ss_count(cfg_ss_count),
    .out_data(out_data), .out_we(out_we), .set_data(set_data), .set_we(set_we),
    .ss_data(ss_data), .ss_we(ss_we), .dir_sel(dir_sel),
    .wait_idx(wait_idx), .wait_pol(wait_pol),
    .in_data(in_data), .wait_met(wait_met),
    .pads_in(pads_in), .pads_out(pads_out), .pads_oe(pads_oe)
  );

  typedef struct {
    logic        rst, dirSel;
    logic        outWe;  logic [4:0] outBase; logic [5:0] outCnt; logic [31:0] outData;
    logic        setWe;  logic [4:0] setBase; logic [2:0] setCnt; logic [4:0]  setData;
    logic        ssWe;   logic [4:0] ssBase;  logic [2:0] ssCnt;  logic [4:0]  ssData;
    logic [31:0] expOut, expOe;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic dirSel,
                        input logic outWe, input int outBase, input int outCnt, input logic [31:0] outData,
                        input logic setWe, input int setBase, input int setCnt, input int setData,
                        input logic ssWe, input int ssBase, input int ssCnt, input int ssData,
                        input logic [31:0] expOut, input logic [31:0] expOe);
    vec_t v;
    v.rst = rst; v.dirSel = dirSel;
    v.outWe = outWe; v.outBase = 5'(outBase); v.outCnt = 6'(outCnt); v.outData = outData;
    v.setWe = setWe; v.setBase = 5'(setBase); v.setCnt = 3'(setCnt); v.setData = 5'(setData);
    v.ssWe = ssWe;   v.ssBase = 5'(ssBase);   v.ssCnt = 3'(ssCnt);   v.ssData = 5'(ssData);
    v.expOut = expOut; v.expOe = expOe;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: write data bit k to pad (base+k) mod N for k below the count.
  function automatic logic [31:0] applyWin(input logic [31:0] cur, input int base, input int cnt,
                                           input logic [31:0] data);
    logic [31:0] r;
    int w;
    r = cur;
    w = (cnt > N) ? N : cnt;
    for (int k = 0; k < w; k++) r[(base + k) % N] = data[k];
    return r;
  endfunction

  // Reference IN window: result bit k is pad (base+k) mod N.
  function automatic logic [31:0] inWin(input logic [31:0] pads, input int base);
    logic [31:0] r;
    for (int k = 0; k < N; k++) r[k] = pads[(base + k) % N];
    return r;
  endfunction

  task automatic idleInputs();
    reset = 0; dir_sel = 0; out_we = 0; set_we = 0; ss_we = 0;
    cfg_in_base = 0; cfg_out_base = 0; cfg_set_base = 0; cfg_ss_base = 0;
    cfg_out_count = 0; cfg_set_count = 0; cfg_ss_count = 0;
    out_data = 0; set_data = 0; ss_data = 0; wait_idx = 0; wait_pol = 0; pads_in = '0;
  endtask

  logic [31:0] mOut, mOe;
  logic [31:0] hist [4];
  logic [31:0] expIn;
  logic        expWait;

  initial begin
    idleInputs();
    reset = 1;
    tick(); tick();
    check("reset_pads_out", pads_out, 32'h0);
    check("reset_pads_oe", pads_oe, 32'h0);
    check("reset_wait_met", 32'(wait_met), 32'h0);

    //      rst dir  oWe oB oC  oData         sWe sB sC sD  ssWe ssB ssC ssD  expOut        expOe
    addVec(1, 0,    1, 0, 32, 32'hFFFFFFFF,  1, 0, 5, 31, 1,   0,  5,  31,  32'h00000000, 32'h00000000);
    addVec(0, 1,    1, 4, 8,  32'h000000FF,  0, 0, 0, 0,  0,   0,  0,  0,   32'h00000000, 32'h00000FF0);
    addVec(0, 0,    1, 4, 8,  32'h000000A5,  0, 0, 0, 0,  0,   0,  0,  0,   32'h00000A50, 32'h00000FF0);
    addVec(1, 0,    0, 0, 0,  32'h0,         0, 0, 0, 0,  0,   0,  0,  0,   32'h00000000, 32'h00000000);
    addVec(0, 0,    1, 30, 4, 32'h0000000F,  0, 0, 0, 0,  0,   0,  0,  0,   32'hC0000003, 32'h00000000);
    addVec(0, 0,    1, 0, 32, 32'hFFFFFFFF,  0, 0, 0, 0,  0,   0,  0,  0,   32'hFFFFFFFF, 32'h00000000);
    addVec(1, 0,    0, 0, 0,  32'h0,         0, 0, 0, 0,  0,   0,  0,  0,   32'h00000000, 32'h00000000);
    // OUT clears pads 0..7, SET drives 2..4 high, SIDESET then clears 3..4.
    addVec(0, 0,    1, 0, 8,  32'h00000000,  1, 2, 3, 7,  1,   3,  2,  0,   32'h00000004, 32'h00000000);
    addVec(0, 0,    1, 0, 8,  32'h00000055,  0, 0, 0, 0,  0,   0,  0,  0,   32'h00000055, 32'h00000000);
    addVec(0, 0,    1, 0, 0,  32'hFFFFFFFF,  1, 0, 0, 31, 1,   0,  0,  31,  32'h00000055, 32'h00000000);
    addVec(0, 1,    1, 0, 0,  32'hFFFFFFFF,  1, 0, 0, 31, 0,   0,  0,  0,   32'h00000055, 32'h00000000);
    // SET spans the 5-pin maximum across the wrap point into the direction register.
    addVec(0, 1,    0, 0, 0,  32'h0,         1, 30, 5, 31, 0,  0,  0,  0,   32'h00000055, 32'hC0000007);
    addVec(1, 0,    1, 0, 32, 32'hFFFFFFFF,  0, 0, 0, 0,  1,   0,  5,  31,  32'h00000000, 32'h00000000);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; dir_sel = vecs[i].dirSel;
      out_we = vecs[i].outWe; cfg_out_base = vecs[i].outBase; cfg_out_count = vecs[i].outCnt; out_data = vecs[i].outData;
      set_we = vecs[i].setWe; cfg_set_base = vecs[i].setBase; cfg_set_count = vecs[i].setCnt; set_data = vecs[i].setData;
      ss_we = vecs[i].ssWe;   cfg_ss_base = vecs[i].ssBase;   cfg_ss_count = vecs[i].ssCnt;   ss_data = vecs[i].ssData;
      tick();
      check($sformatf("vec%0d_pads_out", i), pads_out, vecs[i].expOut);
      check($sformatf("vec%0d_pads_oe", i), pads_oe, vecs[i].expOe);
    end

    // IN window and WAIT latency across the wrap.
    idleInputs();
    reset = 1; tick();
    reset = 0;
    cfg_in_base = 31; wait_idx = 1; wait_pol = 1;
    tick(); tick(); tick();
    pads_in = 32'h80000001;
    #1;
    for (int c = 0; c <= 4; c++) begin
      check($sformatf("in_lat_c%0d", c), in_data, (c >= LAT_IN) ? 32'h3 : 32'h0);
      check($sformatf("wait_lat_c%0d", c), 32'(wait_met), (c >= LAT_W) ? 32'h1 : 32'h0);
      tick();
    end

    // Randomized run against the window-rule reference.
    idleInputs();
    reset = 1; tick();
    mOut = 0; mOe = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    for (int t = 0; t < 400; t++) begin
      reset = ($urandom_range(0, 39) == 0);
      dir_sel = $urandom_range(0, 3) == 0;
      out_we = $urandom_range(0, 1); set_we = $urandom_range(0, 1); ss_we = $urandom_range(0, 1);
      cfg_out_base = 5'($urandom); cfg_set_base = 5'($urandom); cfg_ss_base = 5'($urandom);
      cfg_out_count = 6'($urandom_range(0, 32));
      cfg_set_count = 3'($urandom_range(0, 5)); cfg_ss_count = 3'($urandom_range(0, 5));
      out_data = $urandom; set_data = 5'($urandom); ss_data = 5'($urandom);
      cfg_in_base = 5'($urandom); wait_idx = 5'($urandom); wait_pol = $urandom_range(0, 1);
      pads_in = reset ? '0 : $urandom;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pads_in;
      if (reset) begin
        mOut = 0; mOe = 0;
        expWait = 0;
      end else begin
        if (out_we) begin
          if (dir_sel) mOe = applyWin(mOe, int'(cfg_out_base), int'(cfg_out_count), out_data);
          else         mOut = applyWin(mOut, int'(cfg_out_base), int'(cfg_out_count), out_data);
        end
        if (set_we) begin
          if (dir_sel) mOe = applyWin(mOe, int'(cfg_set_base), int'(cfg_set_count), 32'(set_data));
          else         mOut = applyWin(mOut, int'(cfg_set_base), int'(cfg_set_count), 32'(set_data));
        end
        if (ss_we) mOut = applyWin(mOut, int'(cfg_ss_base), int'(cfg_ss_count), 32'(ss_data));
        expWait = (LAT_IN == 0) ? hist[0][(int'(cfg_in_base) + int'(wait_idx)) % N] == wait_pol
                                : hist[2][(int'(cfg_in_base) + int'(wait_idx)) % N] == wait_pol;
      end
      tick();
      if (reset) for (int i = 1; i < 4; i++) hist[i] = 0;
      expIn = inWin((LAT_IN == 0) ? hist[0] : hist[1], int'(cfg_in_base));
      check($sformatf("rnd%0d_pads_out", t), pads_out, mOut);
      check($sformatf("rnd%0d_pads_oe", t), pads_oe, mOe);
      check($sformatf("rnd%0d_in_data", t), in_data, expIn);
      check($sformatf("rnd%0d_wait_met", t), 32'(wait_met), 32'(expWait));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
